// File: rtl/life_pkg.sv
// life_pkg: shared types, widths and helpers for the Conway arena run-control sequencer
package life_pkg;
  localparam int ARENA_ROW_BITS = 8;
  localparam int GEN_BITS = 32;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    ACK,
    DONE,
    WAIT_PERIOD
  } state_t;

  // Adds a batch to the generation total, clamping at all-ones instead of wrapping
  function automatic logic [GEN_BITS-1:0] sat_add(input logic [GEN_BITS-1:0] a,
                                                  input logic [GEN_BITS-1:0] b);
    logic [GEN_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[GEN_BITS] ? '1 : s[GEN_BITS-1:0];
  endfunction
endpackage

// File: rtl/period_timer.sv
// period_timer: loadable down-counter that flags expiry once after counting value..0
module period_timer #(
  parameter int PERIOD_BITS = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load,
  input  logic [PERIOD_BITS-1:0] value,
  input  logic                   abort,
  output logic                   expired
);
  logic [PERIOD_BITS-1:0] cnt_q, cnt_d;
  logic                   active_q, active_d;

  assign expired = active_q && (cnt_q == '0);

  // Load restarts the count; an armed timer walks down to zero then disarms itself
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = value;
      active_d = 1'b1;
    end else if (abort) begin
      active_d = 1'b0;
    end else if (active_q) begin
      active_d = (cnt_q != '0);
      cnt_d    = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end
  end

  // Counter state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end
endmodule

// File: rtl/life_scheduler.sv
// life_scheduler: run/step/pause sequencer for the Conway solver plus arena port arbiter
module life_scheduler
  import life_pkg::*;
#(
  parameter int ARENA_WIDTH = 10,
  parameter int PERIOD_BITS = 24,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      cmd_run,
  input  logic                      cmd_step,
  input  logic                      cmd_pause,
  input  logic [GEN_BITS-1:0]       batch_size,
  input  logic [PERIOD_BITS-1:0]    period,
  output logic                      solver_start,
  input  logic                      solver_ready,
  output logic [GEN_BITS-1:0]       solver_generations_count,
  input  logic [ARENA_ROW_BITS-1:0] solver_row_select,
  input  logic [ARENA_WIDTH-1:0]    solver_columns_new,
  input  logic                      solver_columns_write,
  input  logic [ARENA_ROW_BITS-1:0] edit_row_select,
  input  logic [ARENA_WIDTH-1:0]    edit_columns_new,
  input  logic                      edit_write,
  output logic                      edit_grant,
  output logic [ARENA_ROW_BITS-1:0] arena_row_select,
  output logic [ARENA_WIDTH-1:0]    arena_columns_new,
  output logic                      arena_columns_write,
  output logic                      running,
  output logic                      busy,
  output logic [GEN_BITS-1:0]       generation,
  output logic                      fault
);
  state_t                 state_q, state_d;
  logic                   running_q, running_d;
  logic                   pend_q, pend_d;
  logic                   fault_q, fault_d;
  logic [GEN_BITS-1:0]    gen_q, gen_d;
  logic [GEN_BITS-1:0]    count_q, count_d;
  logic                   t_load, t_abort, t_expired;
  logic [PERIOD_BITS-1:0] t_value;

  // One timer serves both the ACK timeout and the inter-batch wait; the states never overlap
  period_timer #(.PERIOD_BITS(PERIOD_BITS)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (t_load),
    .value  (t_value),
    .abort  (t_abort),
    .expired(t_expired)
  );

  assign solver_start             = (state_q == LAUNCH);
  assign busy                     = (state_q != IDLE);
  assign edit_grant               = (state_q == IDLE);
  assign solver_generations_count = count_q;
  assign running                  = running_q;
  assign generation               = gen_q;
  assign fault                    = fault_q;
  assign t_abort                  = (state_d == IDLE);
  assign arena_row_select         = edit_grant ? edit_row_select : solver_row_select;
  assign arena_columns_new        = edit_grant ? edit_columns_new : solver_columns_new;
  assign arena_columns_write      = edit_grant ? edit_write : solver_columns_write;

  // Next-state and datapath updates for the run-control sequencer
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    pend_d    = pend_q;
    fault_d   = fault_q;
    gen_d     = gen_q;
    count_d   = count_q;
    t_load    = 1'b0;
    t_value   = period;
    case (state_q)
      IDLE: begin
        pend_d = 1'b0;
        if (cmd_pause) begin
          running_d = 1'b0;
        end else if (cmd_run || cmd_step) begin
          state_d   = LAUNCH;
          running_d = cmd_run;
          fault_d   = 1'b0;
        end
      end
      LAUNCH: begin
        pend_d  = pend_q | cmd_pause;
        count_d = (batch_size == '0) ? GEN_BITS'(1) : batch_size;
        t_load  = 1'b1;
        t_value = PERIOD_BITS'(ACK_TIMEOUT - 1);
        state_d = ACK;
      end
      ACK: begin
        pend_d = pend_q | cmd_pause;
        if (!solver_ready) begin
          state_d = DONE;
        end else if (t_expired) begin
          state_d   = IDLE;
          fault_d   = 1'b1;
          running_d = 1'b0;
          pend_d    = 1'b0;
        end
      end
      DONE: begin
        pend_d = pend_q | cmd_pause;
        if (solver_ready) begin
          gen_d = sat_add(gen_q, count_q);
          if (running_q && !(pend_q | cmd_pause)) begin
            state_d = WAIT_PERIOD;
            t_load  = 1'b1;
          end else begin
            state_d   = IDLE;
            running_d = 1'b0;
            pend_d    = 1'b0;
          end
        end
      end
      WAIT_PERIOD: begin
        if (cmd_pause) begin
          state_d   = IDLE;
          running_d = 1'b0;
        end else if (t_expired) begin
          state_d = LAUNCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      pend_q    <= 1'b0;
      fault_q   <= 1'b0;
      gen_q     <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      running_q <= running_d;
      pend_q    <= pend_d;
      fault_q   <= fault_d;
      gen_q     <= gen_d;
      count_q   <= count_d;
    end
  end
endmodule

// File: tb/tb_life_scheduler.sv
// tb_life_scheduler: directed vectors and sequences for the run-control sequencer
module tb_life_scheduler;
  localparam int AW = 10;
  localparam int PB = 24;
  localparam int AT = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_run = 0, cmd_step = 0, cmd_pause = 0;
  logic [31:0]   batch_size = 0;
  logic [PB-1:0] period = 0;
  logic          solver_start, solver_ready;
  logic [31:0]   solver_generations_count;
  logic [7:0]    solver_row_select = 0, edit_row_select = 0;
  logic [AW-1:0] solver_columns_new = 0, edit_columns_new = 0;
  logic          solver_columns_write = 0, edit_write = 0;
  logic          edit_grant;
  logic [7:0]    arena_row_select;
  logic [AW-1:0] arena_columns_new;
  logic          arena_columns_write, running, busy, fault;
  logic [31:0]   generation;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  life_scheduler #(.ARENA_WIDTH(AW), .PERIOD_BITS(PB), .ACK_TIMEOUT(AT)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_pause(cmd_pause),
    .batch_size(batch_size), .period(period), .solver_start(solver_start),
    .solver_ready(solver_ready), .solver_generations_count(solver_generations_count),
    .solver_row_select(solver_row_select), .solver_columns_new(solver_columns_new),
    .solver_columns_write(solver_columns_write), .edit_row_select(edit_row_select),
    .edit_columns_new(edit_columns_new), .edit_write(edit_write), .edit_grant(edit_grant),
    .arena_row_select(arena_row_select), .arena_columns_new(arena_columns_new),
    .arena_columns_write(arena_columns_write), .running(running), .busy(busy),
    .generation(generation), .fault(fault)
  );

  // Solver model: drops ready on start, raises it again after lat cycles
  int   lat = 16;
  logic hold_ready = 0;
  int   scnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      solver_ready <= 1'b1;
      scnt <= 0;
    end else if (hold_ready) begin
      solver_ready <= 1'b1;
    end else if (solver_start) begin
      solver_ready <= 1'b0;
      scnt <= lat;
    end else if (scnt > 1) begin
      scnt <= scnt - 1;
    end else if (scnt == 1) begin
      scnt <= 0;
      solver_ready <= 1'b1;
    end
  end

  // Start counter and ready-rise to start spacing monitor
  int   cyc = 0, starts = 0, rise_cyc = 0, last_gap = 0;
  logic prev_ready = 1'b1;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_ready <= solver_ready;
    if (solver_start) begin
      starts <= starts + 1;
      last_gap <= cyc - rise_cyc;
    end
    if (solver_ready && !prev_ready) rise_cyc <= cyc;
  end

  typedef struct {
    logic [7:0]    er; logic [AW-1:0] ec; logic ew;
    logic [7:0]    sr; logic [AW-1:0] sc; logic sw;
    logic [7:0]    xr; logic [AW-1:0] xc; logic xw; logic xg;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse(input logic r, input logic s, input logic p);
    cmd_run = r; cmd_step = s; cmd_pause = p;
    @(negedge clk);
    cmd_run = 0; cmd_step = 0; cmd_pause = 0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(busy), 64'd0);
  endtask

  task automatic apply_vec(input int i);
    edit_row_select = tbl[i].er; edit_columns_new = tbl[i].ec; edit_write = tbl[i].ew;
    solver_row_select = tbl[i].sr; solver_columns_new = tbl[i].sc; solver_columns_write = tbl[i].sw;
    #1;
    check($sformatf("port_mux[%0d]", i),
          64'({arena_row_select, arena_columns_new, arena_columns_write, edit_grant}),
          64'({tbl[i].xr, tbl[i].xc, tbl[i].xw, tbl[i].xg}));
  endtask

  task automatic check_reset_values();
    check("rst_start", 64'(solver_start), 64'd0);
    check("rst_count", 64'(solver_generations_count), 64'd0);
    check("rst_running", 64'(running), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_generation", 64'(generation), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_grant", 64'(edit_grant), 64'd1);
  endtask

  initial begin
    int s0, g0, n;
    tbl[0] = '{8'd3,   10'h155, 1'b1, 8'd9,   10'h2AA, 1'b0, 8'd3,   10'h155, 1'b1, 1'b1};
    tbl[1] = '{8'd0,   10'h000, 1'b0, 8'hFF,  10'h3FF, 1'b1, 8'd0,   10'h000, 1'b0, 1'b1};
    tbl[2] = '{8'hFF,  10'h3FF, 1'b1, 8'd0,   10'h000, 1'b0, 8'hFF,  10'h3FF, 1'b1, 1'b1};
    tbl[3] = '{8'h80,  10'h001, 1'b0, 8'h7F,  10'h200, 1'b1, 8'h80,  10'h001, 1'b0, 1'b1};
    tbl[4] = '{8'd3,   10'h155, 1'b1, 8'd9,   10'h2AA, 1'b0, 8'd9,   10'h2AA, 1'b0, 1'b0};
    tbl[5] = '{8'd5,   10'h0F0, 1'b1, 8'h10,  10'h00F, 1'b1, 8'h10,  10'h00F, 1'b1, 1'b0};
    tbl[6] = '{8'hFF,  10'h3FF, 1'b1, 8'd0,   10'h000, 1'b0, 8'd0,   10'h000, 1'b0, 1'b0};
    tbl[7] = '{8'd1,   10'h002, 1'b0, 8'hAB,  10'h155, 1'b1, 8'hAB,  10'h155, 1'b1, 1'b0};

    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_values();

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      apply_vec(i);
    end

    // Single step, batch of 5, 16-cycle solver; editor traffic while busy is dropped
    @(negedge clk);
    batch_size = 5;
    s0 = starts;
    pulse(0, 1, 0);
    check("step_start_high", 64'(solver_start), 64'd1);
    check("step_running", 64'(running), 64'd0);
    for (int i = 4; i < 8; i++) begin
      @(negedge clk);
      apply_vec(i);
    end
    edit_row_select = 0; edit_columns_new = 0; edit_write = 0;
    solver_row_select = 0; solver_columns_new = 0; solver_columns_write = 0;
    wait_idle(60);
    check("step_generation", 64'(generation), 64'd5);
    check("step_one_start", 64'(starts - s0), 64'd1);
    check("step_count", 64'(solver_generations_count), 64'd5);
    check("step_running_end", 64'(running), 64'd0);

    // Zero batch is promoted to one generation
    batch_size = 0;
    pulse(0, 1, 0);
    @(negedge clk);
    check("zero_batch_count", 64'(solver_generations_count), 64'd1);
    wait_idle(60);
    check("zero_batch_gen", 64'(generation), 64'd6);

    // Continuous run, period 3, pause during the second batch
    lat = 4;
    batch_size = 1;
    period = 3;
    s0 = starts;
    pulse(1, 0, 0);
    check("run_running", 64'(running), 64'd1);
    n = 0;
    while (starts - s0 < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("run_second_start", 64'(starts - s0), 64'd2);
    check("run_gap", 64'(last_gap), 64'd5);
    pulse(0, 0, 1);
    wait_idle(60);
    check("run_pause_gen", 64'(generation), 64'd8);
    check("run_pause_running", 64'(running), 64'd0);
    repeat (20) @(negedge clk);
    check("run_no_more_starts", 64'(starts - s0), 64'd2);

    // Pause while waiting between batches
    period = 10;
    g0 = generation;
    s0 = starts;
    pulse(1, 0, 0);
    n = 0;
    while (generation == g0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_gen", 64'(generation), 64'd9);
    check("wait_busy", 64'(busy), 64'd1);
    pulse(0, 0, 1);
    check("wait_pause_idle", 64'(busy), 64'd0);
    check("wait_pause_running", 64'(running), 64'd0);
    repeat (15) @(negedge clk);
    check("wait_no_start", 64'(starts - s0), 64'd1);

    // Pause wins in IDLE; run wins over step
    pulse(1, 1, 1);
    check("idle_pause_priority", 64'(busy), 64'd0);
    pulse(1, 1, 0);
    check("run_beats_step", 64'(running), 64'd1);
    pulse(0, 0, 1);
    wait_idle(60);
    check("run_step_gen", 64'(generation), 64'd10);

    // Solver never acknowledges: timeout after ACK_TIMEOUT cycles
    hold_ready = 1;
    batch_size = 3;
    pulse(0, 1, 0);
    n = 1;
    while (busy && n < 40) begin
      @(negedge clk);
      if (busy) n++;
    end
    check("fault_busy_cycles", 64'(n), 64'(1 + AT));
    check("fault_set", 64'(fault), 64'd1);
    check("fault_running", 64'(running), 64'd0);
    check("fault_gen", 64'(generation), 64'd10);
    hold_ready = 0;
    pulse(0, 1, 0);
    check("fault_cleared", 64'(fault), 64'd0);
    wait_idle(60);
    check("fault_recover_gen", 64'(generation), 64'd13);

    // Saturating generation total
    batch_size = 32'hFFFF_FFF0;
    pulse(0, 1, 0);
    wait_idle(60);
    check("sat_near", 64'(generation), 64'hFFFF_FFFD);
    batch_size = 32'h20;
    pulse(0, 1, 0);
    wait_idle(60);
    check("sat_clamp", 64'(generation), 64'hFFFF_FFFF);

    // Asynchronous reset in the middle of ACK
    lat = 16;
    batch_size = 2;
    pulse(0, 1, 0);
    @(negedge clk);
    check("mid_ack_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_values();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/life_scheduler.md
# life_scheduler

Run-control sequencer for the Conway arena. Accepts run/step/pause commands from the front panel, launches the solver in batches of generations, paces continuous running with a programmable inter-batch period, and keeps a running generation total. Also owns the single arena row port: the editor has it while the solver is idle, and the solver has it while a batch is in flight.

## Interface
- ARENA_WIDTH, 10, cells per arena row
- PERIOD_BITS, 24, width of inter-batch period counter
- ACK_TIMEOUT, 8, cycles to wait for solver to drop ready after start
- clk  in  1  system clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_run  in  1  one-cycle pulse: start continuous running
- cmd_step  in  1  one-cycle pulse: run exactly one batch
- cmd_pause  in  1  one-cycle pulse: stop after current batch
- batch_size  in  32  generations per batch, sampled in LAUNCH
- period  in  PERIOD_BITS  idle cycles between batches in run mode, sampled on entry to WAIT_PERIOD
- solver_start  out  1  launch pulse to solver
- solver_ready  in  1  solver idle flag
- solver_generations_count  out  32  batch length presented to solver
- solver_row_select  in  8, solver_columns_new  in  ARENA_WIDTH, solver_columns_write  in  1  solver-side arena port
- edit_row_select  in  8, edit_columns_new  in  ARENA_WIDTH, edit_write  in  1  editor-side arena port
- edit_grant  out  1  editor owns arena port
- arena_row_select  out  8, arena_columns_new  out  ARENA_WIDTH, arena_columns_write  out  1  muxed arena port
- running  out  1  run mode latched
- busy  out  1  state != IDLE
- generation  out  32  total generations completed, saturating
- fault  out  1  sticky: solver never acknowledged start

## Operation
- States: IDLE, LAUNCH, ACK, DONE, WAIT_PERIOD.
- IDLE: cmd_pause has priority (stay IDLE, clear running). Otherwise cmd_run -> LAUNCH with running=1; else cmd_step -> LAUNCH with running=0. Run beats step when both are pulsed in the same cycle.
- LAUNCH (1 cycle): solver_start=1. Register solver_generations_count = max(batch_size,1). Load ACK timer. -> ACK.
- ACK: solver_ready==0 -> DONE. Timer expires after ACK_TIMEOUT cycles -> IDLE, fault=1, running=0.
- DONE: on solver_ready==1, generation += batch, saturating at 32'hFFFF_FFFF. Then running && !pause_pending -> WAIT_PERIOD, else -> IDLE with running=0 and pause_pending=0.
- WAIT_PERIOD: load counter with period; decrement each cycle; at 0 -> LAUNCH. period==0 gives LAUNCH on the next cycle. cmd_pause here -> IDLE immediately, running=0.
- cmd_pause in LAUNCH/ACK/DONE sets pause_pending. cmd_run/cmd_step outside IDLE are ignored.
- Port mux (combinational): edit_grant = (state==IDLE).
  - Granted: arena_* = edit_*.
  - Otherwise: arena_* = solver_*.
  - Editor writes while not granted are dropped, never queued.
- fault clears only on reset or on the next cmd_run/cmd_step accepted in IDLE.

## Timing
- Reset values: state IDLE, solver_start 0, solver_generations_count 0, running 0, busy 0, generation 0, fault 0, edit_grant 1.
- Command sampled at edge N -> solver_start high for cycle N+1 only.
- Solver drops ready in cycle N+2, so ACK lasts at least 1 cycle.
- generation updates at the edge where DONE sees solver_ready=1; busy falls on the same edge when returning to IDLE.
- Run-mode spacing from ready rising to next solver_start: period+2 cycles.
- Reset mid-batch: all state returns to reset values asynchronously. The solver is reset by the same net.

## Structure
- life_pkg: state enum, ARENA_ROW_BITS=8, GEN_BITS=32, saturating-add function.
- One sub-module: period_timer.
  - Inputs: load, value, abort.
  - Output: expired.
  - Down-counter with PERIOD_BITS width; reused for the ACK timeout.

## Test plan
- Step with batch_size=5 and a 16-cycle solver: exactly one solver_start pulse. generation goes 0->5. running stays 0. Returns to IDLE.
- Run with period=3 and batch_size=1, then pause mid-batch: the current batch completes. generation increments once more, then IDLE. No further solver_start. Gap between batches is 5 cycles.
- Pause during WAIT_PERIOD: IDLE on the next edge. No solver_start.
- batch_size=0: solver_generations_count=1. generation=1 after completion.
- solver_ready held high: fault=1 after ACK_TIMEOUT cycles, state IDLE. A following cmd_step clears fault.
- Editor write while busy: arena_columns_write follows solver_columns_write only. With edit_grant=1, edit_row_select=3 and edit_write=1 pass through in the same cycle.
- Saturation: preload generation near 32'hFFFF_FFFF; result clamps there.
- Reset asserted mid-ACK: all outputs return to reset values.
